// File: rtl/maxf_reduce_if.sv
// Valid/ready stream bundle for maxf_reduce: operand stream in, reduced result out.
interface maxf_reduce_if #(parameter int BITWIDTH = 32);
  logic [BITWIDTH-1:0] ins;
  logic                ins_valid;
  logic                ins_ready;
  logic [BITWIDTH-1:0] outs;
  logic                outs_valid;
  logic                outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/maxf_reduce.sv
// Streaming maximumf reduction: one registered result per GROUP_SIZE accepted inputs,
// with a single output slot that can drain and reload in the same cycle.
module maxf_reduce #(
  parameter int BITWIDTH   = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int GROUP_SIZE = 4
) (
  input logic           clk,
  input logic           rst,
  maxf_reduce_if.slave  s
);

  localparam int FRAC_WIDTH = BITWIDTH - 1 - EXP_WIDTH;
  localparam int CNT_WIDTH  = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(GROUP_SIZE - 1);
  localparam logic [BITWIDTH-1:0]  SIGN_BIT = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0]  QNAN     = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  function automatic logic is_nan(input logic [BITWIDTH-1:0] x);
    return (&x[BITWIDTH-2 -: EXP_WIDTH]) && (|x[FRAC_WIDTH-1:0]);
  endfunction

  // Maps sign-magnitude floats onto an unsigned scale where -0 < +0.
  function automatic logic [BITWIDTH-1:0] order_key(input logic [BITWIDTH-1:0] x);
    return x[BITWIDTH-1] ? ~x : (x | SIGN_BIT);
  endfunction

  function automatic logic [BITWIDTH-1:0] fmax(input logic [BITWIDTH-1:0] a,
                                               input logic [BITWIDTH-1:0] b);
    if (is_nan(a) || is_nan(b))
      return QNAN;
    return (order_key(b) > order_key(a)) ? b : a;
  endfunction

  logic [CNT_WIDTH-1:0] cnt;
  logic [BITWIDTH-1:0]  acc;
  logic [BITWIDTH-1:0]  acc_next;
  logic [BITWIDTH-1:0]  outs_r;
  logic                 outs_valid_r;
  logic                 last;
  logic                 hin;

  assign last        = (cnt == CNT_LAST);
  assign s.ins_ready = ~(last & outs_valid_r & ~s.outs_ready);
  assign hin         = s.ins_valid & s.ins_ready & ~rst;
  // The first element of a group is taken raw, so GROUP_SIZE=1 preserves NaN payloads.
  assign acc_next    = (cnt == '0) ? s.ins : fmax(acc, s.ins);

  assign s.outs       = outs_r;
  assign s.outs_valid = outs_valid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      acc          <= '0;
      outs_r       <= '0;
      outs_valid_r <= 1'b0;
    end else begin
      if (hin) begin
        acc <= acc_next;
        if (last)
          cnt <= '0;
        else
          cnt <= cnt + CNT_WIDTH'(1);
      end
      if (hin && last) begin
        outs_r       <= acc_next;
        outs_valid_r <= 1'b1;
      end else if (outs_valid_r && s.outs_ready) begin
        outs_valid_r <= 1'b0;
      end
    end
  end

endmodule
